// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device model that decodes commands, stores writes, returns CL-delayed read bursts and flags protocol errors.
module sdram_responder #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 10,
  parameter int TRCD = 3,
  parameter int TRP = 3
) (
  input  logic        dram_clk,
  input  logic        reset_n,
  input  logic        dram_cke,
  input  logic        dram_cs_n,
  input  logic        dram_ras_n,
  input  logic        dram_cas_n,
  input  logic        dram_we_n,
  input  logic        dram_ba_0,
  input  logic        dram_ba_1,
  input  logic [12:0] dram_addr,
  input  logic        dram_ldqm,
  input  logic        dram_udqm,
  inout  wire  [15:0] dram_dq,
  output logic [12:0] mode_reg,
  output logic        init_done,
  output logic        protocol_error,
  output logic [3:0]  error_code,
  output logic [15:0] debug_number
);
  localparam int AW = 2 + ROW_BITS + COL_BITS;
  localparam int D = 9;
  typedef enum logic [2:0] {C_MRS, C_REF, C_PRE, C_ACT, C_WR, C_RD, C_BST, C_NOP} cmd_t;
  function automatic logic [COL_BITS-1:0] col_at(input logic [COL_BITS-1:0] c, input logic [2:0] k,
                                                 input logic [3:0] bl, input logic ilv);
    logic [COL_BITS-1:0] m;
    m = COL_BITS'(bl - 4'd1);
    return (c & ~m) | ((ilv ? c ^ COL_BITS'(k) : c + COL_BITS'(k)) & m);
  endfunction
  logic [12:0] r_mode;
  logic [3:0] r_bl, r_wr_bl, r_err, r_open;
  logic [1:0] r_cl, r_ref_cnt, r_wr_ba;
  logic r_ilv, r_single, r_init, r_wr_act, r_wr_ilv;
  logic [7:0] r_cnt;
  logic [ROW_BITS-1:0] r_row [4];
  logic [3:0] r_act_age [4];
  logic [3:0] r_pre_age [4];
  logic [2:0] r_wr_k;
  logic [ROW_BITS-1:0] r_wr_row;
  logic [COL_BITS-1:0] r_wr_col;
  logic [D-1:0] r_q_v;
  logic [AW-1:0] r_q_a [D];
  logic r_oe_lo, r_oe_hi, r_ldqm_d, r_udqm_d;
  logic [15:0] r_dout;
  logic [7:0] r_mem_lo [2**AW];
  logic [7:0] r_mem_hi [2**AW];
  cmd_t w_cmd;
  logic [1:0] w_ba;
  logic [COL_BITS-1:0] w_col, w_wcol;
  logic w_act, w_rw, w_acc, w_rd_ok, w_wr_ok, w_bst, w_pre, w_mode_bad, w_driving, w_burst_beat, w_we;
  logic [3:0] w_err;
  logic [AW-1:0] w_waddr;
  logic [D-1:0] w_q_v;
  logic [AW-1:0] w_q_a [D];
  assign w_cmd = (!dram_cs_n && dram_cke) ? cmd_t'({dram_ras_n, dram_cas_n, dram_we_n}) : C_NOP;
  assign w_ba = {dram_ba_1, dram_ba_0};
  assign w_col = dram_addr[COL_BITS-1:0];
  assign w_act = w_cmd == C_ACT;
  assign w_pre = w_cmd == C_PRE;
  assign w_bst = w_cmd == C_BST;
  assign w_rw = w_cmd == C_RD || w_cmd == C_WR;
  assign w_acc = w_rw && r_init && r_open[w_ba];
  assign w_rd_ok = w_acc && w_cmd == C_RD;
  assign w_wr_ok = w_acc && w_cmd == C_WR;
  assign w_driving = r_oe_lo || r_oe_hi;
  assign w_mode_bad = dram_addr[2] || !(dram_addr[6:4] inside {3'd2, 3'd3}) || |dram_addr[8:7];
  assign w_err = (w_act || w_rw) && !r_init ? 4'd7
               : w_rw && !r_open[w_ba] ? 4'd1
               : w_act && r_open[w_ba] ? 4'd2
               : w_act && r_pre_age[w_ba] < 4'(TRP) ? 4'd6
               : w_rw && r_act_age[w_ba] < 4'(TRCD) ? 4'd5
               : w_cmd == C_WR && w_driving ? 4'd8
               : w_cmd == C_MRS && w_mode_bad ? 4'd4
               : w_cmd == C_REF && |r_open ? 4'd3 : 4'd0;
  assign w_wcol = col_at(r_wr_col, r_wr_k, r_wr_bl, r_wr_ilv);
  assign w_burst_beat = r_wr_act && !w_acc && !w_bst;
  assign w_we = w_wr_ok || w_burst_beat;
  assign w_waddr = w_wr_ok ? {w_ba, r_row[w_ba], w_col} : {r_wr_ba, r_wr_row, w_wcol};
  // Slot i holds the beat that must be stable i+2 edges after the current one.
  always_comb begin
    w_q_v = {1'b0, r_q_v[D-1:1]};
    w_q_a[D-1] = '0;
    for (int i = 0; i < D - 1; i++) w_q_a[i] = r_q_a[i+1];
    for (int i = 0; i < D; i++) begin
      if (w_wr_ok) w_q_v[i] = 1'b0;
      else if ((w_rd_ok || w_bst) && i + 2 >= int'(r_cl)) begin
        w_q_v[i] = w_rd_ok && i + 2 < int'(r_cl) + int'(r_bl);
        w_q_a[i] = {w_ba, r_row[w_ba], col_at(w_col, 3'(i + 2 - int'(r_cl)), r_bl, r_ilv)};
      end
    end
  end
  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= 13'h0030;
      r_bl <= 4'd1;
      r_cl <= 2'd3;
      r_ilv <= 1'b0;
      r_single <= 1'b0;
      r_init <= 1'b0;
      r_ref_cnt <= 2'd0;
      r_err <= 4'd0;
      r_cnt <= 8'd0;
      r_open <= 4'd0;
      r_row <= '{default: '0};
      r_act_age <= '{default: 4'hf};
      r_pre_age <= '{default: 4'hf};
      r_wr_act <= 1'b0;
      r_wr_k <= 3'd0;
      r_wr_ba <= 2'd0;
      r_wr_row <= '0;
      r_wr_col <= '0;
      r_wr_bl <= 4'd1;
      r_wr_ilv <= 1'b0;
      r_q_v <= '0;
      r_q_a <= '{default: '0};
      r_oe_lo <= 1'b0;
      r_oe_hi <= 1'b0;
      r_ldqm_d <= 1'b0;
      r_udqm_d <= 1'b0;
    end else begin
      if (w_cmd != C_NOP) r_cnt <= r_cnt + 8'd1;
      if (r_err == 4'd0) r_err <= w_err;
      if (w_cmd == C_REF && r_ref_cnt != 2'd2) r_ref_cnt <= r_ref_cnt + 2'd1;
      if (w_cmd == C_MRS) begin
        r_mode <= dram_addr;
        r_bl <= w_mode_bad ? 4'd1 : 4'd1 << dram_addr[1:0];
        r_cl <= w_mode_bad ? 2'd3 : {1'b1, dram_addr[4]};
        r_ilv <= !w_mode_bad && dram_addr[3];
        r_single <= dram_addr[9];
        if (r_ref_cnt == 2'd2) r_init <= 1'b1;
      end
      for (int b = 0; b < 4; b++) begin
        if (r_act_age[b] != 4'hf) r_act_age[b] <= r_act_age[b] + 4'd1;
        if (r_pre_age[b] != 4'hf) r_pre_age[b] <= r_pre_age[b] + 4'd1;
        if (w_act && r_init && w_ba == 2'(b)) begin
          r_open[b] <= 1'b1;
          r_row[b] <= dram_addr[ROW_BITS-1:0];
          r_act_age[b] <= 4'd1;
        end
        if ((w_pre && (dram_addr[10] || w_ba == 2'(b))) || (w_acc && dram_addr[10] && w_ba == 2'(b))) begin
          r_open[b] <= 1'b0;
          r_pre_age[b] <= 4'd1;
        end
      end
      if (w_wr_ok) begin
        r_wr_act <= !r_single && r_bl != 4'd1;
        r_wr_k <= 3'd1;
        r_wr_ba <= w_ba;
        r_wr_row <= r_row[w_ba];
        r_wr_col <= w_col;
        r_wr_bl <= r_bl;
        r_wr_ilv <= r_ilv;
      end else if (w_burst_beat) begin
        r_wr_k <= r_wr_k + 3'd1;
        r_wr_act <= 4'(r_wr_k) + 4'd1 < r_wr_bl;
      end else if (w_acc || w_bst) r_wr_act <= 1'b0;
      r_q_v <= w_q_v;
      r_q_a <= w_q_a;
      r_ldqm_d <= dram_ldqm;
      r_udqm_d <= dram_udqm;
      r_oe_lo <= !w_wr_ok && r_q_v[0] && !r_ldqm_d;
      r_oe_hi <= !w_wr_ok && r_q_v[0] && !r_udqm_d;
    end
  end
  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge dram_clk) begin
    if (w_we && !dram_ldqm) r_mem_lo[w_waddr] <= dram_dq[7:0];
    if (w_we && !dram_udqm) r_mem_hi[w_waddr] <= dram_dq[15:8];
    r_dout <= {r_mem_hi[r_q_a[0]], r_mem_lo[r_q_a[0]]};
  end
  assign dram_dq[7:0] = r_oe_lo ? r_dout[7:0] : 8'hzz;
  assign dram_dq[15:8] = r_oe_hi ? r_dout[15:8] : 8'hzz;
  assign mode_reg = r_mode;
  assign init_done = r_init;
  assign error_code = r_err;
  assign protocol_error = |r_err;
  assign debug_number = {r_open, r_err, r_cnt};
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed command vectors with hand-computed bus and status expectations.
module tb_sdram_responder;
  localparam logic [2:0] MRS = 3'd0, REF = 3'd1, ACT = 3'd3, WR = 3'd4, RD = 3'd5, BST = 3'd6, NOP = 3'd7;
  localparam logic [15:0] REL = 16'hffff;
  logic dram_clk = 1'b0, reset_n = 1'b0, cke = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic ba_0 = 1'b0, ba_1 = 1'b0, ldqm = 1'b0, udqm = 1'b0, tb_oe = 1'b0;
  logic [12:0] addr = '0;
  logic [15:0] tb_d = '0;
  wire [15:0] dq;
  logic [12:0] mode_reg;
  logic init_done, protocol_error;
  logic [3:0] error_code;
  logic [15:0] debug_number;
  int n_vec = 0, n_miss = 0;
  always #5 dram_clk = ~dram_clk;
  assign dq = tb_oe ? tb_d : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq[g]);
  end
  sdram_responder dut (
    .dram_clk(dram_clk), .reset_n(reset_n), .dram_cke(cke), .dram_cs_n(cs_n),
    .dram_ras_n(ras_n), .dram_cas_n(cas_n), .dram_we_n(we_n), .dram_ba_0(ba_0), .dram_ba_1(ba_1),
    .dram_addr(addr), .dram_ldqm(ldqm), .dram_udqm(udqm), .dram_dq(dq), .mode_reg(mode_reg),
    .init_done(init_done), .protocol_error(protocol_error), .error_code(error_code),
    .debug_number(debug_number)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic [2:0] c, input logic [1:0] ba = 2'd0, input logic [12:0] a = '0,
                      input logic drv = 1'b0, input logic [15:0] d = '0, input logic lm = 1'b0,
                      input logic um = 1'b0);
    cs_n = (c == NOP);
    {ras_n, cas_n, we_n} = c;
    {ba_1, ba_0} = ba;
    addr = a;
    tb_oe = drv;
    tb_d = d;
    ldqm = lm;
    udqm = um;
    @(posedge dram_clk);
    @(negedge dram_clk);
  endtask
  task automatic init_seq();
    tick(REF);
    tick(REF);
    tick(MRS, 2'd0, 13'h022);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge dram_clk);
    check("rst_mode", {3'b0, mode_reg}, 16'h0030);
    check("rst_init", 16'(init_done), 16'd0);
    check("rst_perr", 16'(protocol_error), 16'd0);
    check("rst_ecode", 16'(error_code), 16'd0);
    check("rst_dbg", debug_number, 16'h0000);
    check("rst_dq", dq, REL);
    reset_n = 1'b1;
    init_seq();
    check("init_done", 16'(init_done), 16'd1);
    check("init_mode", {3'b0, mode_reg}, 16'h0022);
    check("init_ecode", 16'(error_code), 16'd0);
    check("init_dbg", debug_number, 16'h0003);
    tick(ACT, 2'd1, 13'd5);
    check("act_dbg", debug_number, 16'h2004);
    tick(NOP);
    tick(NOP);
    tick(WR, 2'd1, 13'd4, 1'b1, 16'haaa1);
    tick(NOP, 2'd0, 13'd0, 1'b1, 16'hbbb2);
    tick(NOP, 2'd0, 13'd0, 1'b1, 16'hccc3);
    tick(NOP, 2'd0, 13'd0, 1'b1, 16'hddd4);
    tick(RD, 2'd1, 13'd6);
    check("rd_pre", dq, REL);
    tick(NOP);
    check("rd_b0", dq, 16'hccc3);
    tick(NOP);
    check("rd_b1", dq, 16'hddd4);
    tick(NOP);
    check("rd_b2", dq, 16'haaa1);
    tick(NOP);
    check("rd_b3", dq, 16'hbbb2);
    tick(NOP);
    check("rd_post", dq, REL);
    tick(WR, 2'd1, 13'd8, 1'b1, 16'hffff);
    tick(NOP, 2'd0, 13'd0, 1'b1, 16'h5a5a);
    tick(NOP, 2'd0, 13'd0, 1'b1, 16'h6b6b);
    tick(NOP, 2'd0, 13'd0, 1'b1, 16'h7c7c);
    tick(WR, 2'd1, 13'd8, 1'b1, 16'h1234, 1'b0, 1'b1);
    tick(BST);
    tick(RD, 2'd1, 13'd8);
    tick(NOP, 2'd0, 13'd0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("msk_b0", dq, 16'hff34);
    tick(NOP);
    check("msk_b1", dq, 16'h5aff);
    tick(NOP);
    check("msk_b2", dq, 16'h6b6b);
    tick(NOP);
    check("msk_b3", dq, 16'h7c7c);
    tick(RD, 2'd2, 13'd0);
    check("closed_ecode", 16'(error_code), 16'd1);
    check("closed_perr", 16'(protocol_error), 16'd1);
    tick(NOP);
    check("closed_dq0", dq, REL);
    tick(NOP);
    check("closed_dq1", dq, REL);
    tick(ACT, 2'd1, 13'd5);
    check("sticky_ecode", 16'(error_code), 16'd1);
    reset_n = 1'b0;
    repeat (2) @(negedge dram_clk);
    reset_n = 1'b1;
    init_seq();
    check("reinit_done", 16'(init_done), 16'd1);
    tick(ACT, 2'd1, 13'd5);
    tick(RD, 2'd1, 13'd4);
    check("trcd_ecode", 16'(error_code), 16'd5);
    tick(NOP);
    check("trcd_b0", dq, 16'haaa1);
    tick(NOP);
    check("trcd_b1", dq, 16'hbbb2);
    tick(NOP);
    check("trcd_b2", dq, 16'hccc3);
    tick(NOP);
    check("trcd_b3", dq, 16'hddd4);
    tick(NOP);
    tick(MRS, 2'd0, 13'h033);
    check("bl8_mode", {3'b0, mode_reg}, 16'h0033);
    tick(RD, 2'd1, 13'd8);
    check("bst_n1", dq, REL);
    tick(NOP);
    check("bst_n2", dq, REL);
    tick(BST);
    check("bst_b0", dq, 16'hff34);
    tick(NOP);
    check("bst_b1", dq, 16'h5a5a);
    tick(NOP);
    check("bst_cut0", dq, REL);
    tick(NOP);
    check("bst_cut1", dq, REL);
    tick(RD, 2'd1, 13'd8);
    tick(NOP);
    tick(NOP);
    check("mid_b0", dq, 16'hff34);
    reset_n = 1'b0;
    #1;
    check("arst_dq", dq, REL);
    check("arst_mode", {3'b0, mode_reg}, 16'h0030);
    check("arst_init", 16'(init_done), 16'd0);
    check("arst_perr", 16'(protocol_error), 16'd0);
    check("arst_ecode", 16'(error_code), 16'd0);
    check("arst_dbg", debug_number, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
